// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control FSM: opcodes, datapath select codes, states.
package ctrl_pkg;

   localparam int OP_ADD  = 0;
   localparam int OP_ADDI = 1;
   localparam int OP_NAND = 2;
   localparam int OP_LUI  = 3;
   localparam int OP_LW   = 4;
   localparam int OP_SW   = 5;
   localparam int OP_BEQ  = 6;
   localparam int OP_JALR = 7;

   localparam logic [1:0] FUNC_ALU_ADD   = 2'b00;
   localparam logic [1:0] FUNC_ALU_NAND  = 2'b01;
   localparam logic [1:0] FUNC_ALU_PASS1 = 2'b10;
   localparam logic [1:0] FUNC_ALU_EQ    = 2'b11;

   localparam logic [1:0] MUX_PC_NONE   = 2'b00;
   localparam logic [1:0] MUX_PC_NEXT   = 2'b01;
   localparam logic [1:0] MUX_PC_BRANCH = 2'b10;
   localparam logic [1:0] MUX_PC_JUMP   = 2'b11;

   localparam logic [1:0] MUX_TGT_NONE = 2'b00;
   localparam logic [1:0] MUX_TGT_ALU  = 2'b01;
   localparam logic [1:0] MUX_TGT_DMEM = 2'b10;
   localparam logic [1:0] MUX_TGT_PC   = 2'b11;

   typedef enum logic [2:0] {
      ST_BOOT   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6,
      ST_FAULT  = 3'd7
   } state_t;

   typedef struct packed {
      logic [1:0] func_alu;
      logic       mux_alu1;
      logic       mux_alu2;
      logic       mux_rf;
   } alu_sel_t;

endpackage

// File: rtl/ctrl_wait_timer.sv
// Memory-wait watchdog: counts unacknowledged wait cycles and flags the cycle that hits the limit.
module ctrl_wait_timer #(
   parameter int TIMEOUT = 15,
   parameter int TO_W    = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic inc,
   input  logic ack,
   output logic expired
);

   localparam logic [TO_W-1:0] LIMIT = (TIMEOUT == 0) ? '1 : TO_W'(TIMEOUT);

   logic [TO_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_cnt <= '0;
      else if (clear)
         r_cnt <= '0;
      else if (inc && !ack && (r_cnt != LIMIT))
         r_cnt <= r_cnt + 1'b1;
   end

   // The TIMEOUT-th unacknowledged cycle expires; an ack on that same cycle wins.
   assign expired = (TIMEOUT != 0) && inc && !ack && (r_cnt >= LIMIT - 1'b1);

endmodule

// File: rtl/control_mc.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath enables/selects.
module control_mc
   import ctrl_pkg::*;
#(
   parameter int OPC_W   = 3,
   parameter int TIMEOUT = 15,
   parameter int TO_W    = 4,
   parameter int HALT_EN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [OPC_W-1:0] opcode,
   input  logic             eq,
   input  logic             halt_bit,
   input  logic             imem_ack,
   input  logic             dmem_ack,
   output logic             imem_req,
   output logic             dmem_req,
   output logic             we_dmem,
   output logic             we_ir,
   output logic             we_pc,
   output logic             we_rf,
   output logic [1:0]       func_alu,
   output logic             mux_alu1,
   output logic             mux_alu2,
   output logic [1:0]       mux_pc,
   output logic             mux_rf,
   output logic [1:0]       mux_tgt,
   output logic             retire,
   output logic             halted,
   output logic             fault
);

   function automatic alu_sel_t decode_sel(input logic [OPC_W-1:0] op);
      alu_sel_t s;
      s = '0;
      case (op)
         OPC_W'(OP_ADDI): s.mux_alu2 = 1'b1;
         OPC_W'(OP_NAND): s.func_alu = FUNC_ALU_NAND;
         OPC_W'(OP_LUI):  begin s.func_alu = FUNC_ALU_PASS1; s.mux_alu1 = 1'b1; end
         OPC_W'(OP_LW):   s.mux_alu2 = 1'b1;
         OPC_W'(OP_SW):   begin s.mux_alu2 = 1'b1; s.mux_rf = 1'b1; end
         OPC_W'(OP_BEQ):  begin s.func_alu = FUNC_ALU_EQ; s.mux_rf = 1'b1; end
         default:         s = '0;
      endcase
      return s;
   endfunction

   state_t   r_state;
   state_t   w_next;
   alu_sel_t w_sel;
   logic     w_wait, w_ack, w_clear, w_expired;
   logic     w_is_lw, w_is_sw;

   assign w_sel   = decode_sel(opcode);
   assign w_is_lw = (opcode == OPC_W'(OP_LW));
   assign w_is_sw = (opcode == OPC_W'(OP_SW));
   assign w_wait  = (r_state == ST_FETCH) || (r_state == ST_MEM);
   assign w_ack   = (r_state == ST_FETCH) ? imem_ack : dmem_ack;
   // Restarting on every state change gives a fresh budget on each entry to FETCH/MEM.
   assign w_clear = !w_wait || (w_next != r_state);

   ctrl_wait_timer #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (w_clear),
      .inc     (w_wait),
      .ack     (w_ack),
      .expired (w_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_BOOT;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      imem_req = 1'b0;
      dmem_req = 1'b0;
      we_dmem  = 1'b0;
      we_ir    = 1'b0;
      we_pc    = 1'b0;
      we_rf    = 1'b0;
      func_alu = FUNC_ALU_ADD;
      mux_alu1 = 1'b0;
      mux_alu2 = 1'b0;
      mux_pc   = MUX_PC_NONE;
      mux_rf   = 1'b0;
      mux_tgt  = MUX_TGT_NONE;
      halted   = 1'b0;
      fault    = 1'b0;
      if ((r_state == ST_EXEC) || (r_state == ST_MEM) || (r_state == ST_WB))
         {func_alu, mux_alu1, mux_alu2, mux_rf} = w_sel;
      case (r_state)
         ST_BOOT: w_next = ST_FETCH;
         ST_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               we_ir  = 1'b1;
               w_next = ST_DECODE;
            end else if (w_expired) begin
               w_next = ST_FAULT;
            end
         end
         ST_DECODE: w_next = ST_EXEC;
         ST_EXEC: begin
            case (opcode)
               OPC_W'(OP_LW), OPC_W'(OP_SW): w_next = ST_MEM;
               OPC_W'(OP_BEQ): begin
                  we_pc  = 1'b1;
                  mux_pc = eq ? MUX_PC_BRANCH : MUX_PC_NEXT;
                  w_next = ST_FETCH;
               end
               OPC_W'(OP_JALR): begin
                  if ((HALT_EN != 0) && halt_bit) begin
                     w_next = ST_HALT;
                  end else begin
                     we_rf   = 1'b1;
                     mux_tgt = MUX_TGT_PC;
                     we_pc   = 1'b1;
                     mux_pc  = MUX_PC_JUMP;
                     w_next  = ST_FETCH;
                  end
               end
               default: w_next = ST_WB;
            endcase
         end
         ST_MEM: begin
            dmem_req = 1'b1;
            we_dmem  = w_is_sw;
            if (dmem_ack) begin
               we_pc  = 1'b1;
               mux_pc = MUX_PC_NEXT;
               if (w_is_lw) begin
                  we_rf   = 1'b1;
                  mux_tgt = MUX_TGT_DMEM;
               end
               w_next = ST_FETCH;
            end else if (w_expired) begin
               w_next = ST_FAULT;
            end
         end
         ST_WB: begin
            we_rf   = 1'b1;
            mux_tgt = MUX_TGT_ALU;
            we_pc   = 1'b1;
            mux_pc  = MUX_PC_NEXT;
            w_next  = ST_FETCH;
         end
         ST_HALT:  halted = 1'b1;
         ST_FAULT: fault  = 1'b1;
         default:  w_next = ST_BOOT;
      endcase
   end

   assign retire = we_pc;

endmodule

// File: tb/tb_control_mc.sv
// Self-checking bench for control_mc: directed scenarios plus a random instruction stream vs a trace model.
module tb_control_mc;

   typedef struct packed {
      logic       imem_req, dmem_req, we_dmem, we_ir, we_pc, we_rf;
      logic [1:0] func_alu;
      logic       mux_alu1, mux_alu2;
      logic [1:0] mux_pc;
      logic       mux_rf;
      logic [1:0] mux_tgt;
      logic       retire, halted, fault;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] opcode = '0;
   logic       eq = 1'b0, halt_bit = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;

   logic       a_imem_req, a_dmem_req, a_we_dmem, a_we_ir, a_we_pc, a_we_rf;
   logic [1:0] a_func_alu, a_mux_pc, a_mux_tgt;
   logic       a_mux_alu1, a_mux_alu2, a_mux_rf, a_retire, a_halted, a_fault;
   logic       b_imem_req, b_dmem_req, b_we_dmem, b_we_ir, b_we_pc, b_we_rf;
   logic [1:0] b_func_alu, b_mux_pc, b_mux_tgt;
   logic       b_mux_alu1, b_mux_alu2, b_mux_rf, b_retire, b_halted, b_fault;

   obs_t obs, obs_nh;
   assign obs    = {a_imem_req, a_dmem_req, a_we_dmem, a_we_ir, a_we_pc, a_we_rf, a_func_alu,
                    a_mux_alu1, a_mux_alu2, a_mux_pc, a_mux_rf, a_mux_tgt, a_retire, a_halted, a_fault};
   assign obs_nh = {b_imem_req, b_dmem_req, b_we_dmem, b_we_ir, b_we_pc, b_we_rf, b_func_alu,
                    b_mux_alu1, b_mux_alu2, b_mux_pc, b_mux_rf, b_mux_tgt, b_retire, b_halted, b_fault};

   control_mc #(.OPC_W(3), .TIMEOUT(15), .TO_W(4), .HALT_EN(1)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .eq(eq), .halt_bit(halt_bit),
      .imem_ack(imem_ack), .dmem_ack(dmem_ack),
      .imem_req(a_imem_req), .dmem_req(a_dmem_req), .we_dmem(a_we_dmem), .we_ir(a_we_ir),
      .we_pc(a_we_pc), .we_rf(a_we_rf), .func_alu(a_func_alu), .mux_alu1(a_mux_alu1),
      .mux_alu2(a_mux_alu2), .mux_pc(a_mux_pc), .mux_rf(a_mux_rf), .mux_tgt(a_mux_tgt),
      .retire(a_retire), .halted(a_halted), .fault(a_fault)
   );

   control_mc #(.OPC_W(3), .TIMEOUT(15), .TO_W(4), .HALT_EN(0)) dut_nh (
      .clk(clk), .rst(rst), .opcode(opcode), .eq(eq), .halt_bit(halt_bit),
      .imem_ack(imem_ack), .dmem_ack(dmem_ack),
      .imem_req(b_imem_req), .dmem_req(b_dmem_req), .we_dmem(b_we_dmem), .we_ir(b_we_ir),
      .we_pc(b_we_pc), .we_rf(b_we_rf), .func_alu(b_func_alu), .mux_alu1(b_mux_alu1),
      .mux_alu2(b_mux_alu2), .mux_pc(b_mux_pc), .mux_rf(b_mux_rf), .mux_tgt(b_mux_tgt),
      .retire(b_retire), .halted(b_halted), .fault(b_fault)
   );

   always #5 clk = ~clk;

   int n_vec = 0, n_err = 0, n_ret = 0, exp_ret = 0;

   always @(posedge clk) if (a_retire === 1'b1) n_ret <= n_ret + 1;

   task automatic chk(input string tag, input obs_t got, input obs_t exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int got, input int exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Opcode table: ALU function and operand/read-port selects held through EXEC/MEM/WB.
   function automatic obs_t sel_of(input logic [2:0] op);
      obs_t s;
      s = '0;
      case (op)
         3'd1: s.mux_alu2 = 1'b1;
         3'd2: s.func_alu = 2'b01;
         3'd3: begin s.func_alu = 2'b10; s.mux_alu1 = 1'b1; end
         3'd4: s.mux_alu2 = 1'b1;
         3'd5: begin s.mux_alu2 = 1'b1; s.mux_rf = 1'b1; end
         3'd6: begin s.func_alu = 2'b11; s.mux_rf = 1'b1; end
         default: s = '0;
      endcase
      return s;
   endfunction

   // Plays one instruction from FETCH entry: wi/wd wait cycles before the imem/dmem ack.
   task automatic run_instr(input logic [2:0] op, input logic e, input int wi, input int wd,
                            input string tag);
      obs_t x;
      opcode = op; eq = e; halt_bit = 1'b0;
      for (int k = 0; k <= wi; k++) begin
         imem_ack = (k == wi);
         x = '0; x.imem_req = 1'b1; x.we_ir = (k == wi);
         #1 chk({tag, "/fetch"}, obs, x);
         tick();
      end
      imem_ack = 1'b0;
      #1 chk({tag, "/decode"}, obs, '0);
      tick();
      x = sel_of(op);
      if (op == 3'd6) begin
         x.we_pc = 1'b1; x.retire = 1'b1; x.mux_pc = e ? 2'b10 : 2'b01;
      end else if (op == 3'd7) begin
         x.we_rf = 1'b1; x.mux_tgt = 2'b11; x.we_pc = 1'b1; x.retire = 1'b1; x.mux_pc = 2'b11;
      end
      #1 chk({tag, "/exec"}, obs, x);
      tick();
      if (op == 3'd4 || op == 3'd5) begin
         for (int k = 0; k <= wd; k++) begin
            dmem_ack = (k == wd);
            x = sel_of(op); x.dmem_req = 1'b1; x.we_dmem = (op == 3'd5);
            if (k == wd) begin
               x.we_pc = 1'b1; x.retire = 1'b1; x.mux_pc = 2'b01;
               if (op == 3'd4) begin x.we_rf = 1'b1; x.mux_tgt = 2'b10; end
            end
            #1 chk({tag, "/mem"}, obs, x);
            tick();
         end
         dmem_ack = 1'b0;
      end else if (op < 3'd4) begin
         x = sel_of(op);
         x.we_rf = 1'b1; x.mux_tgt = 2'b01; x.we_pc = 1'b1; x.mux_pc = 2'b01; x.retire = 1'b1;
         #1 chk({tag, "/wb"}, obs, x);
         tick();
      end
      exp_ret++;
   endtask

   initial begin
      obs_t x;
      int   base;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk("reset", obs, '0);
      rst = 1'b0;
      #1 chk("boot", obs, '0);
      tick();

      base = n_ret; exp_ret = 0;
      run_instr(3'd0, 1'b0, 0, 0, "add");
      chk_int("add_retire", n_ret - base, 1);
      run_instr(3'd6, 1'b1, 0, 0, "beq_taken");
      run_instr(3'd6, 1'b0, 0, 0, "beq_not");
      run_instr(3'd5, 1'b0, 0, 3, "sw_wait3");

      for (int i = 0; i < 40; i++)
         run_instr(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 4), $urandom_range(0, 4), "rand");
      chk_int("retire_count", n_ret - base, exp_ret);

      // Reset while an LW sits in MEM; a late dmem ack during BOOT must be ignored.
      opcode = 3'd4; imem_ack = 1'b1; tick();
      imem_ack = 1'b0; tick(); tick();
      x = sel_of(3'd4); x.dmem_req = 1'b1;
      #1 chk("mem_before_rst", obs, x);
      rst = 1'b1;
      #1 chk("rst_mid_mem", obs, '0);
      tick();
      dmem_ack = 1'b1;
      tick();
      rst = 1'b0;
      #1 chk("boot_late_ack", obs, '0);
      tick();
      dmem_ack = 1'b0;
      x = '0; x.imem_req = 1'b1;
      #1 chk("fetch_after_rst", obs, x);
      tick();
      // That cycle was fetch wait #1; 14 more unacked cycles reach the limit.
      for (int k = 1; k < 15; k++) begin
         #1 chk("to_wait", obs, x);
         tick();
      end
      x = '0; x.fault = 1'b1;
      #1 chk("to_fault", obs, x);
      imem_ack = 1'b1; dmem_ack = 1'b1;
      tick(); tick();
      #1 chk("fault_sticky", obs, x);
      imem_ack = 1'b0; dmem_ack = 1'b0;
      rst = 1'b1; tick();
      rst = 1'b0; tick();
      run_instr(3'd0, 1'b0, 14, 0, "ack_at_limit");

      // JALR with halt_bit: halts with HALT_EN=1, jumps with HALT_EN=0.
      opcode = 3'd7; halt_bit = 1'b1; imem_ack = 1'b1; tick();
      imem_ack = 1'b0; tick();
      #1 chk("halt_exec", obs, sel_of(3'd7));
      x = sel_of(3'd7);
      x.we_rf = 1'b1; x.mux_tgt = 2'b11; x.we_pc = 1'b1; x.mux_pc = 2'b11; x.retire = 1'b1;
      chk("nohalt_exec", obs_nh, x);
      tick();
      x = '0; x.halted = 1'b1;
      #1 chk("halted", obs, x);
      x = '0; x.imem_req = 1'b1;
      chk("nohalt_fetch", obs_nh, x);
      imem_ack = 1'b1; dmem_ack = 1'b1; opcode = 3'd0;
      tick(); tick();
      x = '0; x.halted = 1'b1;
      #1 chk("halt_sticky", obs, x);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
